// File: rtl/serial_pkg.sv
// rtl/serial_pkg.sv - shared serial constants, receiver FSM states and baud rounding.
// SERIAL_RX_PARITY_EN adds the PARITY state.
package serial_pkg;

    localparam int DEFAULT_CLK_HZ = 25_000_000;
    localparam int DEFAULT_BAUD   = 115_200;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
`ifdef SERIAL_RX_PARITY_EN
        ST_PARITY,
`endif
        ST_STOP,
        ST_WAIT_IDLE
    } rx_state_t;

    // Rounded to nearest so transmitter and receiver agree on the bit period.
    function automatic int clks_per_bit(input int clk_hz, input int baud);
        return (clk_hz + baud / 2) / baud;
    endfunction

endpackage

// File: rtl/serial_bit_sampler.sv
// rtl/serial_bit_sampler.sv - per-bit clock counter with 3-sample majority vote at bit centre.
module serial_bit_sampler #(
    parameter int CLKS_PER_BIT = 217
) (
    input  logic clk,
    input  logic rst,
    input  logic restart,
    input  logic rx_s,
    output logic decide,
    output logic rx_bit
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int HALF  = CLKS_PER_BIT / 2;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_S0   = CNT_W'(HALF - 1);
    localparam logic [CNT_W-1:0] CNT_S1   = CNT_W'(HALF);
    localparam logic [CNT_W-1:0] CNT_S2   = CNT_W'(HALF + 1);

    logic [CNT_W-1:0] cnt;
    logic [1:0]       votes;

    // The restart edge itself is count 0, so the counter resumes at 1 and
    // cnt equals cycles elapsed since the start edge, modulo the bit period.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt   <= '0;
            votes <= '0;
        end else begin
            if (restart) begin
                cnt <= CNT_W'(1);
            end else if (cnt == CNT_LAST) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
            if (cnt == CNT_S0) begin
                votes[0] <= rx_s;
            end
            if (cnt == CNT_S1) begin
                votes[1] <= rx_s;
            end
        end
    end

    assign decide = (cnt == CNT_S2);
    assign rx_bit = (votes[0] & votes[1]) | (votes[0] & rx_s) | (votes[1] & rx_s);

endmodule

// File: rtl/serial_rx.sv
// rtl/serial_rx.sv - 8N1 asynchronous serial receiver, LSB first, idle-high line.
// SERIAL_RX_PARITY_EN adds an even parity bit and the RxD_parity_err pulse.
module serial_rx
    import serial_pkg::*;
#(
    parameter int CLK_HZ = DEFAULT_CLK_HZ,
    parameter int BAUD   = DEFAULT_BAUD
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       RxD,
    output logic [7:0] RxD_data,
    output logic       RxD_valid,
    output logic       RxD_busy,
    output logic       RxD_frame_err,
    output logic       RxD_parity_err
);

    localparam int CLKS_PER_BIT = clks_per_bit(CLK_HZ, BAUD);

    rx_state_t  state, state_nx;
    logic       rx_m, rx_s;
    logic [7:0] shreg;
    logic [2:0] idx;
    logic       restart, decide, rx_bit;
    logic       shift_en, load_data, valid_nx, ferr_nx;
`ifdef SERIAL_RX_PARITY_EN
    logic       perr_nx;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
        end else begin
            rx_m <= RxD;
            rx_s <= rx_m;
        end
    end

    serial_bit_sampler #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_sampler (
        .clk    (clk),
        .rst    (rst),
        .restart(restart),
        .rx_s   (rx_s),
        .decide (decide),
        .rx_bit (rx_bit)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        restart   = 1'b0;
        shift_en  = 1'b0;
        load_data = 1'b0;
        valid_nx  = 1'b0;
        ferr_nx   = 1'b0;
`ifdef SERIAL_RX_PARITY_EN
        perr_nx   = 1'b0;
`endif
        case (state)
            ST_IDLE: begin
                if (!rx_s) begin
                    state_nx = ST_START;
                    restart  = 1'b1;
                end
            end
            ST_START: begin
                if (decide) begin
                    state_nx = rx_bit ? ST_IDLE : ST_DATA;
                end
            end
            ST_DATA: begin
                if (decide) begin
                    shift_en = 1'b1;
                    if (idx == 3'd7) begin
`ifdef SERIAL_RX_PARITY_EN
                        state_nx = ST_PARITY;
`else
                        state_nx = ST_STOP;
`endif
                    end
                end
            end
`ifdef SERIAL_RX_PARITY_EN
            ST_PARITY: begin
                if (decide) begin
                    perr_nx  = rx_bit ^ (^shreg);
                    state_nx = ST_STOP;
                end
            end
`endif
            ST_STOP: begin
                if (decide) begin
                    if (rx_bit) begin
                        load_data = 1'b1;
                        valid_nx  = 1'b1;
                        state_nx  = ST_IDLE;
                    end else begin
                        ferr_nx  = 1'b1;
                        state_nx = ST_WAIT_IDLE;
                    end
                end
            end
            ST_WAIT_IDLE: begin
                if (rx_s) begin
                    state_nx = ST_IDLE;
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shreg         <= '0;
            idx           <= '0;
            RxD_data      <= '0;
            RxD_valid     <= 1'b0;
            RxD_frame_err <= 1'b0;
        end else begin
            if (restart) begin
                idx <= '0;
            end else if (shift_en) begin
                idx <= idx + 3'd1;
            end
            if (shift_en) begin
                shreg <= {rx_bit, shreg[7:1]};
            end
            if (load_data) begin
                RxD_data <= shreg;
            end
            RxD_valid     <= valid_nx;
            RxD_frame_err <= ferr_nx;
        end
    end

`ifdef SERIAL_RX_PARITY_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            RxD_parity_err <= 1'b0;
        end else begin
            RxD_parity_err <= perr_nx;
        end
    end
`else
    assign RxD_parity_err = 1'b0;
`endif

    assign RxD_busy = (state != ST_IDLE);

endmodule

// File: tb/tb_serial_rx.sv
// tb/tb_serial_rx.sv - randomized self-checking bench for serial_rx against a frame-level model.
`timescale 1ns/1ps
module tb_serial_rx;

    localparam int CPB  = (25_000_000 + 115_200 / 2) / 115_200;
    localparam int HALF = CPB / 2;
`ifdef SERIAL_RX_PARITY_EN
    localparam int PBITS = 1;
`else
    localparam int PBITS = 0;
`endif
    // Pin change after edge n: synchronizer puts T0 at n+3; valid shows after T0+HALF+1+(9+PBITS)*CPB.
    localparam int VALID_LAT = 3 + HALF + 1 + (9 + PBITS) * CPB;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       RxD = 1'b1;
    logic [7:0] RxD_data;
    logic       RxD_valid, RxD_busy, RxD_frame_err, RxD_parity_err;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int ferr_cnt = 0;
    int perr_cnt = 0;
    int last_start = 0;
    logic [7:0] last_good = 8'h00;
    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];
    int         got_cyc[$];

    serial_rx dut (
        .clk           (clk),
        .rst           (rst),
        .RxD           (RxD),
        .RxD_data      (RxD_data),
        .RxD_valid     (RxD_valid),
        .RxD_busy      (RxD_busy),
        .RxD_frame_err (RxD_frame_err),
        .RxD_parity_err(RxD_parity_err)
    );

    always #20 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (RxD_valid) begin
            got_q.push_back(RxD_data);
            got_cyc.push_back(cyc);
        end
        if (RxD_frame_err) ferr_cnt = ferr_cnt + 1;
        if (RxD_parity_err) perr_cnt = perr_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks = checks + 1;
        if (got !== exp) begin
            failures = failures + 1;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic hold(input logic v, input int n);
        RxD = v;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop, input logic par_flip);
        logic pbit;
        pbit = (^b) ^ par_flip;
        last_start = cyc;
        hold(1'b0, CPB);
        for (int i = 0; i < 8; i++) hold(b[i], CPB);
        if (PBITS == 1) hold(pbit, CPB);
        hold(stop, CPB);
        if (stop) begin
            exp_q.push_back(b);
            last_good = b;
        end
    endtask

    task automatic wait_idle(input string tag);
        int k;
        k = 0;
        while (RxD_busy && k < 5 * CPB) begin
            @(negedge clk);
            k++;
        end
        chk({tag, "_idle"}, {31'd0, RxD_busy}, 32'd0);
    endtask

    task automatic drain(input string tag);
        chk({tag, "_count"}, got_q.size(), exp_q.size());
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            chk({tag, "_byte"}, {24'd0, got_q.pop_front()}, {24'd0, exp_q.pop_front()});
        end
        exp_q.delete();
        got_q.delete();
        got_cyc.delete();
    endtask

    initial begin
        string      msg;
        logic [7:0] b;
        int         t, f0, p0;
        msg = "Hello World!\n";

        repeat (4) @(negedge clk);
        chk("rst_data", {24'd0, RxD_data}, 32'd0);
        chk("rst_valid", {31'd0, RxD_valid}, 32'd0);
        chk("rst_busy", {31'd0, RxD_busy}, 32'd0);
        chk("rst_ferr", {31'd0, RxD_frame_err}, 32'd0);
        chk("rst_perr", {31'd0, RxD_parity_err}, 32'd0);
        rst = 1'b1;
        repeat (3) @(negedge clk);

        send_frame(8'h48, 1'b1, 1'b0);
        t = last_start;
        hold(1'b1, CPB);
        wait_idle("h");
        chk("h_latency", (got_cyc.size() > 0) ? got_cyc[0] : -1, t + VALID_LAT);
        chk("h_ferr", ferr_cnt, 0);
        drain("h");

        for (int i = 0; i < msg.len(); i++) send_frame(msg[i], 1'b1, 1'b0);
        hold(1'b1, CPB);
        wait_idle("hello");
        drain("hello");

        repeat (5) begin
            b = 8'($urandom);
            send_frame(b, 1'b1, 1'b0);
            hold(1'b1, $urandom_range(0, 3 * CPB));
        end
        hold(1'b1, CPB);
        drain("rand");

        t = cyc;
        hold(1'b0, 50);
        RxD = 1'b1;
        while (cyc < t + 3 + HALF) @(negedge clk);
        chk("glitch_busy_hi", {31'd0, RxD_busy}, 32'd1);
        @(negedge clk);
        chk("glitch_busy_lo", {31'd0, RxD_busy}, 32'd0);
        hold(1'b1, 2 * CPB);
        drain("glitch");

        f0 = ferr_cnt;
        send_frame(8'h55, 1'b0, 1'b0);
        hold(1'b0, 3 * CPB);
        hold(1'b1, 2 * CPB);
        chk("fe_pulse", ferr_cnt - f0, 1);
        chk("fe_keep", {24'd0, RxD_data}, {24'd0, last_good});
        chk("fe_busy", {31'd0, RxD_busy}, 32'd0);
        send_frame(8'hA5, 1'b1, 1'b0);
        hold(1'b1, CPB);
        drain("fe");

        b = 8'h3C;
        hold(1'b0, CPB);
        for (int i = 0; i < 4; i++) hold(b[i], CPB);
        hold(b[4], CPB / 2);
        rst = 1'b0;
        RxD = 1'b1;
        repeat (3) @(negedge clk);
        chk("mid_rst_busy", {31'd0, RxD_busy}, 32'd0);
        chk("mid_rst_data", {24'd0, RxD_data}, 32'd0);
        rst = 1'b1;
        hold(1'b1, 2 * CPB);
        send_frame(8'h81, 1'b1, 1'b0);
        hold(1'b1, CPB);
        wait_idle("mid_rst");
        drain("mid_rst");

        p0 = perr_cnt;
`ifdef SERIAL_RX_PARITY_EN
        send_frame(8'h07, 1'b1, 1'b1);
        hold(1'b1, CPB);
        chk("par_err_pulse", perr_cnt - p0, 1);
        drain("par");
`else
        chk("par_err_never", perr_cnt - p0, 0);
        chk("par_err_total", perr_cnt, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/serial_rx.md
# serial_rx

- Asynchronous serial receiver, 8 data bits, LSB first, 1 stop bit, idle-high line.
- Complements the existing serial transmitter: it sits between a board UART RX pin and user logic.
- Recovers bytes using a per-bit clock counter with 3-sample majority voting at each bit centre.
- Presents each byte as a one-cycle valid pulse with held data, and flags framing errors.

## Interface
- CLK_HZ, 25_000_000, system clock frequency in Hz
- BAUD, 115200, line rate in bit/s
- CLKS_PER_BIT, (CLK_HZ + BAUD/2)/BAUD = 217, derived, not overridden; must be ≥ 8
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  reset, asynchronous assert, active-low (0 = reset)
- RxD  in  1  serial line from pin, asynchronous to clk
- RxD_data  out  8  last correctly received byte, stable between valid pulses
- RxD_valid  out  1  one-cycle pulse, RxD_data updated in the same cycle
- RxD_busy  out  1  high in every state except IDLE
- RxD_frame_err  out  1  one-cycle pulse on bad stop bit
- RxD_parity_err  out  1  one-cycle pulse on parity mismatch; constant 0 without the macro

## Operation
- RxD passes through a 2-flop synchronizer (reset value 1); the FSM uses only the synchronized bit `rx_s`.
- Bit counter `cnt` has width $clog2(CLKS_PER_BIT); HALF = CLKS_PER_BIT/2 = 108.
- A vote register captures `rx_s` at cnt = HALF-1, HALF and HALF+1; the bit decision is the majority, taken at cnt = HALF+1.
- FSM states: IDLE, START, DATA, [PARITY], STOP, WAIT_IDLE.
- IDLE → START: when `rx_s` = 0; `cnt` is cleared.
- START, at decision: majority 1 (glitch) → IDLE with no output. Majority 0 → DATA, with `cnt` wrapping so each following decision lands exactly CLKS_PER_BIT cycles later.
- DATA: 8 decisions shifted in LSB first, tracked by a 3-bit index. After bit 7 → PARITY if compiled in, else STOP.
- STOP, majority 1: RxD_data ← shift register, RxD_valid = 1 for one cycle, then IDLE.
- STOP, majority 0: RxD_frame_err = 1 for one cycle, RxD_data unchanged, then WAIT_IDLE.
- WAIT_IDLE: remains until `rx_s` = 1 (this covers a break condition), then IDLE. No new start is accepted in this state.
- A back-to-back start bit is handled: a falling edge in the first cycle after STOP → IDLE is detected normally.
- Reset at any time: state IDLE, `cnt` 0, shift register 0, all outputs 0, synchronizer flops 1. A partial frame is discarded.

## Timing
- Let T0 be the first clk edge at which `rx_s` = 0.
- Start decision: T0 + HALF + 1.
- Data bit k decision: T0 + HALF + 1 + (k+1)·CLKS_PER_BIT.
- Stop decision, and RxD_valid / RxD_frame_err in the same cycle: T0 + HALF + 1 + 9·CLKS_PER_BIT = T0 + 2062 at defaults (add CLKS_PER_BIT with parity).
- Pin-to-T0 latency: 2 cycles (synchronizer).
- RxD_busy rises the cycle after T0 and falls the cycle after the stop decision or the WAIT_IDLE exit.
- There is no backpressure: the consumer must sample RxD_data on RxD_valid. A later byte overwrites it.

## Configuration
- SERIAL_RX_PARITY_EN defined:
  - Adds state PARITY, one extra bit between data and stop, decided identically.
  - Even parity: mismatch pulses RxD_parity_err at the parity decision.
  - The FSM still proceeds to STOP. RxD_valid still fires if the stop bit is good, so the consumer discards the byte.
- Macro undefined: no PARITY state, RxD_parity_err tied 0.

## Structure
- serial_pkg holds:
  - the FSM state enum
  - the default CLK_HZ and BAUD constants
  - the clks-per-bit rounding function, shared with the transmitter
- Sub-module `serial_bit_sampler` contains the `cnt` counter, the 3-sample vote and a `decide` strobe. The FSM only restarts it and consumes `decide` / `bit`.

## Test plan
- Reset, then send 0x48 ('H') at 217 clk/bit → RxD_valid pulses once at T0+2062 with RxD_data = 0x48, and RxD_frame_err stays 0.
- Send "Hello World!\n" back-to-back with no idle gap → 13 valid pulses with the correct bytes in order.
- 50-cycle low glitch on idle line → no valid pulse, and RxD_busy returns to 0 at T0+110.
- Send 0x55 with stop bit held 0, then the line stays low for 3 bit times → RxD_frame_err pulses once, RxD_data keeps its previous value, and the next good 0xA5 is received.
- Assert rst during data bit 4 of 0x3C, then send 0x81 → no valid for 0x3C; 0x81 is received.
- With SERIAL_RX_PARITY_EN, send 0x07 with parity bit 0 → RxD_parity_err pulses, then RxD_valid pulses with 0x07.
